// File: rtl/perf_event_counter_bank_if.sv
// Read-port bundle for perf_event_counter_bank: request/select toward the bank, ack/data back.
interface perf_event_counter_bank_if #(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 32
);
    localparam int SELW = $clog2(NUM_EVENTS + 1);

    logic                 rd_req;
    logic [SELW-1:0]      rd_sel;
    logic                 rd_ack;
    logic [CNT_WIDTH-1:0] rd_data;

    modport master (output rd_req, rd_sel, input rd_ack, rd_data);
    modport slave  (input rd_req, rd_sel, output rd_ack, rd_data);
endinterface

// File: rtl/perf_event_counter_bank.sv
// Per-channel event counters plus a run-cycle counter, frozen on halt, read via a registered req/ack port.
// Optional macro PERF_SNAPSHOT_EN adds a snap input and a shadow bank that the read port returns.
module perf_event_counter_bank #(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int CYC_WIDTH  = 32,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_EVENTS-1:0] event_vec,
    input  logic                  halt,
    input  logic                  clear,
`ifdef PERF_SNAPSHOT_EN
    input  logic                  snap,
`endif
    perf_event_counter_bank_if.slave rd,
    output logic [NUM_EVENTS-1:0] overflow,
    output logic                  frozen,
    output logic [CYC_WIDTH-1:0]  cycle_count
);
    localparam int SELW = $clog2(NUM_EVENTS + 1);
    localparam int NSRC = 1 << SELW;

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    state_t state_reg, state_next;
    logic   count_en;

    logic [NUM_EVENTS-1:0] ovf_hit;
    logic [CNT_WIDTH-1:0]  src_cnt [NUM_EVENTS];
    logic [CYC_WIDTH-1:0]  cyc_reg, cyc_next, src_cyc;
    logic [CNT_WIDTH-1:0]  cyc_rd;
    logic [CNT_WIDTH-1:0]  rd_src [NSRC];
    logic                  rd_ack_reg;
    logic [CNT_WIDTH-1:0]  rd_data_reg;

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // clear outranks halt in RUN, so a same-cycle halt+clear never freezes
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!clear && enable) state_next = RUN;
            RUN: begin
                if (!clear) begin
                    if (halt)         state_next = FROZEN;
                    else if (!enable) state_next = IDLE;
                end
            end
            FROZEN:  if (clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_en = 1'b0;
        frozen   = 1'b0;
        case (state_reg)
            RUN:     count_en = !clear;
            FROZEN:  frozen   = 1'b1;
            default: ;
        endcase
    end

`ifdef PERF_SNAPSHOT_EN
    logic snap_load;
    assign snap_load = snap || ((state_reg == RUN) && (state_next == FROZEN));
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
            logic                 hit;

            always_comb begin
                cnt_next = cnt_reg;
                hit      = 1'b0;
                if (clear) begin
                    cnt_next = '0;
                end else if (count_en && event_vec[gi]) begin
                    if (&cnt_reg) begin
                        hit      = 1'b1;
                        cnt_next = (SATURATE != 0) ? cnt_reg : '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) cnt_reg <= '0;
                else      cnt_reg <= cnt_next;
            end

            assign ovf_hit[gi] = hit;

`ifdef PERF_SNAPSHOT_EN
            // shadow takes the post-edge value so a freeze captures the halt-cycle events
            logic [CNT_WIDTH-1:0] shd_reg;
            always_ff @(posedge clk) begin
                if (!rst || clear) shd_reg <= '0;
                else if (snap_load) shd_reg <= cnt_next;
            end
            assign src_cnt[gi] = shd_reg;
`else
            assign src_cnt[gi] = cnt_reg;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst || clear) overflow <= '0;
        else               overflow <= overflow | ovf_hit;
    end

    always_comb begin
        cyc_next = cyc_reg;
        if (clear)         cyc_next = '0;
        else if (count_en) cyc_next = cyc_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) cyc_reg <= '0;
        else      cyc_reg <= cyc_next;
    end

    assign cycle_count = cyc_reg;

`ifdef PERF_SNAPSHOT_EN
    logic [CYC_WIDTH-1:0] shd_cyc_reg;
    always_ff @(posedge clk) begin
        if (!rst || clear) shd_cyc_reg <= '0;
        else if (snap_load) shd_cyc_reg <= cyc_next;
    end
    assign src_cyc = shd_cyc_reg;
`else
    assign src_cyc = cyc_reg;
`endif

    generate
        if (CYC_WIDTH >= CNT_WIDTH) begin : g_cyc_trunc
            assign cyc_rd = src_cyc[CNT_WIDTH-1:0];
        end else begin : g_cyc_ext
            assign cyc_rd = {{(CNT_WIDTH-CYC_WIDTH){1'b0}}, src_cyc};
        end

        // full power-of-two source table so any encodable select indexes it directly
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            if (gi < NUM_EVENTS) begin : g_evt
                assign rd_src[gi] = src_cnt[gi];
            end else if (gi == NUM_EVENTS) begin : g_cyc
                assign rd_src[gi] = cyc_rd;
            end else begin : g_zero
                assign rd_src[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ack_reg  <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            rd_ack_reg <= rd.rd_req;
            if (rd.rd_req) rd_data_reg <= rd_src[rd.rd_sel];
        end
    end

    assign rd.rd_ack  = rd_ack_reg;
    assign rd.rd_data = rd_data_reg;
endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Directed bench: a 32-bit bank plus 8-bit saturating and wrapping banks share one stimulus stream.
module tb_perf_event_counter_bank;
    localparam int NE   = 8;
    localparam int SELW = $clog2(NE + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, enable, halt, clear, snap, rd_req;
    logic [NE-1:0]   event_vec;
    logic [SELW-1:0] rd_sel;

    logic [NE-1:0] ovf_m, ovf_s, ovf_w;
    logic          frz_m, frz_s, frz_w;
    logic [31:0]   cyc_m, cyc_s, cyc_w;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dm;
    logic [7:0]  ds, dw;

    logic [SELW-1:0] b2b_sel [4] = '{4'd8, 4'd9, 4'd0, 4'd8};
    logic [31:0]     b2b_exp [4] = '{32'd20, 32'd0, 32'd0, 32'd20};

    perf_event_counter_bank_if #(.NUM_EVENTS(NE), .CNT_WIDTH(32)) ifm ();
    perf_event_counter_bank_if #(.NUM_EVENTS(NE), .CNT_WIDTH(8))  ifs ();
    perf_event_counter_bank_if #(.NUM_EVENTS(NE), .CNT_WIDTH(8))  ifw ();

    assign ifm.rd_req = rd_req;
    assign ifm.rd_sel = rd_sel;
    assign ifs.rd_req = rd_req;
    assign ifs.rd_sel = rd_sel;
    assign ifw.rd_req = rd_req;
    assign ifw.rd_sel = rd_sel;

    perf_event_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(32), .CYC_WIDTH(32), .SATURATE(1)) dut_m (
        .clk(clk), .rst(rst), .enable(enable), .event_vec(event_vec), .halt(halt), .clear(clear),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd(ifm), .overflow(ovf_m), .frozen(frz_m), .cycle_count(cyc_m));

    perf_event_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(8), .CYC_WIDTH(32), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .event_vec(event_vec), .halt(halt), .clear(clear),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd(ifs), .overflow(ovf_s), .frozen(frz_s), .cycle_count(cyc_s));

    perf_event_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(8), .CYC_WIDTH(32), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .enable(enable), .event_vec(event_vec), .halt(halt), .clear(clear),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd(ifw), .overflow(ovf_w), .frozen(frz_w), .cycle_count(cyc_w));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic do_snap();
`ifdef PERF_SNAPSHOT_EN
        snap = 1'b1;
        tick();
        snap = 1'b0;
`endif
    endtask

    task automatic do_read(input logic [SELW-1:0] sel, input bit snap_first,
                           output logic [31:0] d_m, output logic [7:0] d_s, output logic [7:0] d_w);
        if (snap_first) do_snap();
        rd_req = 1'b1;
        rd_sel = sel;
        tick();
        rd_req = 1'b0;
        check("rd_ack_pulse", ifm.rd_ack, 1);
        d_m = ifm.rd_data;
        d_s = ifs.rd_data;
        d_w = ifw.rd_data;
        tick();
        check("rd_ack_drop", ifm.rd_ack, 0);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; halt = 1'b0; clear = 1'b0; snap = 1'b0;
        event_vec = '0; rd_req = 1'b1; rd_sel = '0;

        // a read issued while reset is held is dropped
        tick();
        check("rst_read_dropped", ifm.rd_ack, 0);
        rd_req = 1'b0;
        tick();
        check("rst_frozen", frz_m, 0);
        check("rst_cycle", cyc_m, 0);
        check("rst_overflow", ovf_m, 0);
        check("rst_rd_data", ifm.rd_data, 0);
        rst = 1'b1;

        // ten cycles of events on channels 0 and 1
        enable = 1'b1;
        tick();
        event_vec = 8'h03;
        repeat (10) tick();
        event_vec = '0;
        check("cycle_after_10", cyc_m, 10);
        enable = 1'b0;
        tick();
        check("cycle_idle_exit", cyc_m, 11);
        do_read(0, 1, dm, ds, dw); check("sel0_10", dm, 10); check("sel0_10_cw8", ds, 10);
        do_read(1, 1, dm, ds, dw); check("sel1_10", dm, 10);
        do_read(2, 1, dm, ds, dw); check("sel2_0", dm, 0);
        do_read(8, 1, dm, ds, dw); check("sel_cycle_11", dm, 11);
        do_read(9, 1, dm, ds, dw); check("sel_oob9", dm, 0);
        do_read(15, 1, dm, ds, dw); check("sel_oob15", dm, 0);

        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_cycle", cyc_m, 0);
        do_read(0, 1, dm, ds, dw); check("clear_sel0", dm, 0);

        // halt on the fifth event cycle freezes at 5
        enable = 1'b1;
        tick();
        event_vec = 8'h01;
        repeat (4) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_frozen", frz_m, 1);
        check("halt_cycle", cyc_m, 5);
        event_vec = 8'hFF;
        enable = 1'b0; repeat (3) tick();
        enable = 1'b1; repeat (3) tick();
        halt = 1'b1; tick(); halt = 1'b0;
        event_vec = '0;
        check("frozen_hold", frz_m, 1);
        check("frozen_cycle", cyc_m, 5);
        do_read(0, 1, dm, ds, dw); check("frozen_sel0", dm, 5);
        clear = 1'b1; enable = 1'b0; tick(); clear = 1'b0;
        check("unfreeze", frz_m, 0);
        check("unfreeze_cycle", cyc_m, 0);
        do_read(0, 1, dm, ds, dw); check("unfreeze_sel0", dm, 0);

        // halt and clear together: clear wins, bank stays in RUN
        enable = 1'b1;
        tick();
        event_vec = 8'h01;
        repeat (7) tick();
        event_vec = '0;
        do_read(0, 1, dm, ds, dw); check("pre_hc_sel0", dm, 7);
        halt = 1'b1; clear = 1'b1; event_vec = 8'h01;
        tick();
        halt = 1'b0; clear = 1'b0; event_vec = '0;
        check("hc_frozen", frz_m, 0);
        check("hc_cycle", cyc_m, 0);
        event_vec = 8'h01; tick(); event_vec = '0;
        do_read(0, 1, dm, ds, dw); check("hc_still_run", dm, 1);
        check("hc_overflow", ovf_m, 0);

        // cycle counter readback after 20 RUN cycles
        enable = 1'b0; tick();
        clear = 1'b1; tick(); clear = 1'b0;
        enable = 1'b1; tick();
        repeat (19) tick();
        enable = 1'b0; tick();
        check("cycle_20", cyc_m, 20);
        do_read(8, 1, dm, ds, dw); check("sel_cycle_20", dm, 20);

        // back-to-back requests
        do_snap();
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_sel = b2b_sel[i];
            tick();
            check("b2b_ack", ifm.rd_ack, 1);
            check("b2b_data", ifm.rd_data, b2b_exp[i]);
        end
        rd_req = 1'b0;
        tick();
        check("b2b_ack_end", ifm.rd_ack, 0);
        check("b2b_data_hold", ifm.rd_data, 20);

        // 300 events on channel 2: saturate vs wrap in the 8-bit banks
        clear = 1'b1; tick(); clear = 1'b0;
        enable = 1'b1; tick();
        event_vec = 8'h04;
        repeat (300) tick();
        event_vec = '0;
        enable = 1'b0; tick();
        do_read(2, 1, dm, ds, dw);
        check("sel2_300_cw32", dm, 300);
        check("sel2_sat", ds, 255);
        check("sel2_wrap", dw, 44);
        check("ovf_sat", ovf_s, 8'h04);
        check("ovf_wrap", ovf_w, 8'h04);
        check("ovf_cw32", ovf_m, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        check("ovf_clear_sat", ovf_s, 0);
        check("ovf_clear_wrap", ovf_w, 0);

`ifdef PERF_SNAPSHOT_EN
        enable = 1'b1; tick();
        event_vec = 8'h01; repeat (3) tick(); event_vec = '0;
        snap = 1'b1; tick(); snap = 1'b0;
        event_vec = 8'h01; repeat (4) tick(); event_vec = '0;
        do_read(0, 0, dm, ds, dw); check("snap_sel0", dm, 3);
        halt = 1'b1; tick(); halt = 1'b0;
        do_read(0, 0, dm, ds, dw); check("snap_freeze_sel0", dm, 7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/perf_event_counter_bank.md
Name: perf_event_counter_bank

Overview:
- Synthesizable, parametrised performance-monitor block that sits beside the pipeline.
- Counts per-cycle event strobes in N independent channels, e.g. retired instruction, I-cache request/hit, D-cache request/hit.
- Also keeps a run-cycle counter.
- Freezes all counts when the processor halts, so software or bench logic can read the final totals through a registered request/acknowledge port.

Parameters:
- NUM_EVENTS, 8: number of event channels (1..16).
- CNT_WIDTH, 32: width of each event counter and of rd_data (8..32).
- CYC_WIDTH, 32: width of the cycle counter (8..32).
- SATURATE, 1: 1 = counters stick at all-ones on overflow; 0 = counters wrap to zero.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  counting enable (level).
- event_vec  input  NUM_EVENTS  one strobe per channel; sampled every cycle.
- halt  input  1  processor halt retired (pulse or level).
- clear  input  1  synchronous clear of counters and overflow flags.
- rd_req  input  1  read request, one request per high cycle.
- rd_sel  input  SELW  channel select, SELW = $clog2(NUM_EVENTS+1).
- rd_ack  output  1  read data valid, one-cycle pulse.
- rd_data  output  CNT_WIDTH  read data.
- overflow  output  NUM_EVENTS  sticky per-channel overflow flags.
- frozen  output  1  high while in FROZEN.
- cycle_count  output  CYC_WIDTH  live cycle counter.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE.
  - All counters, cycle_count, overflow, rd_ack, rd_data and frozen are 0.
  - Reset overrides every other input.
- FSM states: IDLE, RUN, FROZEN.
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0 and halt=0.
  - RUN -> FROZEN when halt=1 (enable ignored).
  - FROZEN -> IDLE only on clear=1; halt and enable are ignored while FROZEN.
  - IDLE ignores halt.
- Counting happens only in RUN.
  - Channel i increments by 1 when event_vec[i]=1.
  - cycle_count increments every RUN cycle.
  - Events and the cycle on the halt cycle itself are counted. The new values are visible one cycle later, with frozen=1.
- Overflow: an increment attempted while a counter is all-ones sets overflow[i]=1 (sticky).
  - SATURATE=1: the value stays all-ones.
  - SATURATE=0: the value becomes 0.
  - The cycle counter always wraps and has no flag.
- clear:
  - Zeros all event counters, cycle_count and overflow in the same edge.
  - Beats increment in the same cycle.
  - Beats halt in the same cycle, so there is no freeze.
  - State effect: FROZEN goes to IDLE; RUN and IDLE are unchanged.
- Read port:
  - rd_req=1 at edge T gives rd_ack=1 at T+1, with rd_data = the register value held just before edge T (pre-increment).
  - rd_sel<NUM_EVENTS returns counter[rd_sel].
  - rd_sel==NUM_EVENTS returns cycle_count, truncated or zero-extended to CNT_WIDTH.
  - rd_sel>NUM_EVENTS returns 0, with the ack still given.
  - Back-to-back requests give back-to-back acks; there is no stall.
  - Reads are legal in every state and never disturb counting.
  - rd_data holds its last value when rd_ack=0.
- A read in flight when rst is asserted is dropped: rd_ack=0 next cycle.

Optional Feature:
- Macro PERF_SNAPSHOT_EN.
- When defined:
  - An extra input snap (1 bit) is added.
  - snap=1 copies all event counters and cycle_count into a shadow bank in one edge. Entry into FROZEN also copies them.
  - Reads return shadow values.
  - clear zeros the shadow bank too.
  - snap and clear in the same cycle: clear wins.
- When undefined: no snap port and no shadow storage; reads return live values.

Test Plan:
- Reset then enable=1; event_vec=8'b0000_0011 for 10 cycles; read sel 0, 1 and 2 -> rd_data 10, 10, 0; each ack exactly 1 cycle after its req.
- RUN with event_vec[0]=1 for 5 cycles, halt pulsed on the 5th -> frozen=1 next cycle; sel0 reads 5; further events and enable toggles leave the value 5; clear -> frozen=0, sel0 reads 0.
- CNT_WIDTH=8, SATURATE=1, event_vec[2] held for 300 cycles -> sel2=255, overflow[2]=1. Same with SATURATE=0 -> sel2=44, overflow[2]=1.
- Same-cycle halt+clear in RUN after 7 counts -> counters 0, frozen stays 0, state RUN.
- rd_sel=NUM_EVENTS after 20 RUN cycles -> 20. rd_sel=NUM_EVENTS+1 (where encodable) -> 0 with ack. Back-to-back reqs over 4 cycles -> 4 consecutive acks.
- PERF_SNAPSHOT_EN: 3 counts, snap, then 4 more counts -> sel0 reads 3. Halt -> sel0 reads 7.
